// File: rtl/display_defs.sv
// Shared definitions for the VGA character-write path: field widths,
// requester identities and the write sequencer state encoding.
package display_defs;

  localparam int ROW_W_DEFAULT  = 8;
  localparam int COL_W_DEFAULT  = 8;
  localparam int CHAR_W_DEFAULT = 8;

  localparam logic OWNER_TYPER = 1'b0;
  localparam logic OWNER_CPU   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/typer_hold_reg.sv
// One-entry holding register for fire-and-forget typer pulses, with a
// saturating count of pulses that arrived while the entry was occupied.
module typer_hold_reg
  import display_defs::*;
#(
  parameter int ROW_W  = ROW_W_DEFAULT,
  parameter int COL_W  = COL_W_DEFAULT,
  parameter int CHAR_W = CHAR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              typ_start,
  input  logic [ROW_W-1:0]  typ_row,
  input  logic [COL_W-1:0]  typ_col,
  input  logic [CHAR_W-1:0] typ_char,
  input  logic              grant,
  output logic              pending,
  output logic [ROW_W-1:0]  hold_row,
  output logic [COL_W-1:0]  hold_col,
  output logic [CHAR_W-1:0] hold_char,
  output logic [7:0]        drop_count
);

  logic              pending_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic [CHAR_W-1:0] char_reg;
  logic [7:0]        drop_reg;
  logic              capture;

  // A grant frees the entry in the same cycle, so a simultaneous pulse refills it.
  assign capture = typ_start && (!pending_reg || grant);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_reg <= 1'b0;
      row_reg     <= '0;
      col_reg     <= '0;
      char_reg    <= '0;
      drop_reg    <= 8'd0;
    end else begin
      if (capture) begin
        pending_reg <= 1'b1;
        row_reg     <= typ_row;
        col_reg     <= typ_col;
        char_reg    <= typ_char;
      end else if (grant) begin
        pending_reg <= 1'b0;
      end
      if (typ_start && !capture && drop_reg != 8'hFF) begin
        drop_reg <= drop_reg + 8'd1;
      end
    end
  end

  assign pending    = pending_reg;
  assign hold_row   = row_reg;
  assign hold_col   = col_reg;
  assign hold_char  = char_reg;
  assign drop_count = drop_reg;

endmodule

// File: rtl/char_write_arbiter.sv
// Round-robin arbiter sharing the character-write engine between the typer
// and the processor. Optional done watchdog: define CHARWR_TIMEOUT_EN.
module char_write_arbiter
  import display_defs::*;
#(
  parameter int ROW_W          = ROW_W_DEFAULT,
  parameter int COL_W          = COL_W_DEFAULT,
  parameter int CHAR_W         = CHAR_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ROW_W-1:0]  typ_row,
  input  logic [COL_W-1:0]  typ_col,
  input  logic [CHAR_W-1:0] typ_char,
  input  logic              typ_start,
  output logic              typ_pending,
  input  logic [ROW_W-1:0]  cpu_row,
  input  logic [COL_W-1:0]  cpu_col,
  input  logic [CHAR_W-1:0] cpu_char,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  output logic [ROW_W-1:0]  wr_row,
  output logic [COL_W-1:0]  wr_col,
  output logic [CHAR_W-1:0] wr_char,
  output logic              wr_start,
  input  logic              wr_done,
  output logic              busy,
  output logic              grant_owner,
  output logic [7:0]        drop_count,
  output logic              timeout_flag
);

  wr_state_t         state_reg, state_next;
  logic              last_owner_reg;
  logic              grant_owner_reg;
  logic [ROW_W-1:0]  wr_row_reg;
  logic [COL_W-1:0]  wr_col_reg;
  logic [CHAR_W-1:0] wr_char_reg;

  logic              hold_pending;
  logic [ROW_W-1:0]  hold_row;
  logic [COL_W-1:0]  hold_col;
  logic [CHAR_W-1:0] hold_char;
  logic              grant_typ, grant_cpu;
  logic              timeout_hit;

  typer_hold_reg #(
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .CHAR_W (CHAR_W)
  ) u_hold (
    .clock      (clock),
    .resetn     (resetn),
    .typ_start  (typ_start),
    .typ_row    (typ_row),
    .typ_col    (typ_col),
    .typ_char   (typ_char),
    .grant      (grant_typ),
    .pending    (hold_pending),
    .hold_row   (hold_row),
    .hold_col   (hold_col),
    .hold_char  (hold_char),
    .drop_count (drop_count)
  );

  // Under contention the requester that did not own the previous write wins.
  always_comb begin
    grant_typ = 1'b0;
    grant_cpu = 1'b0;
    if (state_reg == IDLE) begin
      grant_typ = hold_pending && (!cpu_valid || last_owner_reg == OWNER_CPU);
      grant_cpu = cpu_valid && (!hold_pending || last_owner_reg == OWNER_TYPER);
    end
  end

`ifdef CHARWR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_flag_reg;

  assign timeout_hit = (state_reg == WAIT) && !wr_done &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_reg     <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      if (state_reg == ISSUE) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (timeout_hit) begin
        timeout_flag_reg <= 1'b1;
      end
    end
  end

  assign timeout_flag = timeout_flag_reg;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_typ || grant_cpu) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wr_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      last_owner_reg  <= OWNER_CPU;
      grant_owner_reg <= 1'b0;
      wr_row_reg      <= '0;
      wr_col_reg      <= '0;
      wr_char_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_typ) begin
        last_owner_reg  <= OWNER_TYPER;
        grant_owner_reg <= OWNER_TYPER;
        wr_row_reg      <= hold_row;
        wr_col_reg      <= hold_col;
        wr_char_reg     <= hold_char;
      end else if (grant_cpu) begin
        last_owner_reg  <= OWNER_CPU;
        grant_owner_reg <= OWNER_CPU;
        wr_row_reg      <= cpu_row;
        wr_col_reg      <= cpu_col;
        wr_char_reg     <= cpu_char;
      end
    end
  end

  assign typ_pending = hold_pending;
  assign cpu_ready   = grant_cpu;
  assign wr_start    = (state_reg == ISSUE);
  assign busy        = (state_reg != IDLE);
  assign grant_owner = grant_owner_reg;
  assign wr_row      = wr_row_reg;
  assign wr_col      = wr_col_reg;
  assign wr_char     = wr_char_reg;

endmodule
